seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 7-segment driver: samples the scanned an/seg lines and reconstructs the four displayed hex digits.
- Reports per-digit glyph validity, blanking, frame-complete pulses and a stale-display flag.
- Sits beside the game top level, on the same clk, as a self-check and readback block for the score and seconds display.
- Replaces ad-hoc printing of an/seg with registered, checkable outputs.

---
 rtl/seg_scan_decoder.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuilds four scanned hex digits from multiplexed an/seg lines
// and reports per-digit validity, blanking, frame commits and display staleness.
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        stale
);

  localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [23:0] TMO_MAX   = 24'(TIMEOUT);

  // returns {valid, blank, value}
  function automatic logic [5:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'b1000000: decode_glyph = {2'b10, 4'h0};
      7'b1111001: decode_glyph = {2'b10, 4'h1};
      7'b0100100: decode_glyph = {2'b10, 4'h2};
      7'b0110000: decode_glyph = {2'b10, 4'h3};
      7'b0011001: decode_glyph = {2'b10, 4'h4};
      7'b0010010: decode_glyph = {2'b10, 4'h5};
      7'b0000010: decode_glyph = {2'b10, 4'h6};
      7'b1111000: decode_glyph = {2'b10, 4'h7};
      7'b0000000: decode_glyph = {2'b10, 4'h8};
      7'b0010000: decode_glyph = {2'b10, 4'h9};
      7'b0001000: decode_glyph = {2'b10, 4'hA};
      7'b0000011: decode_glyph = {2'b10, 4'hB};
      7'b1000110: decode_glyph = {2'b10, 4'hC};
      7'b0100001: decode_glyph = {2'b10, 4'hD};
      7'b0000110: decode_glyph = {2'b10, 4'hE};
      7'b0001110: decode_glyph = {2'b10, 4'hF};
      7'b1111111: decode_glyph = {2'b01, 4'h0};
      default:    decode_glyph = {2'b00, 4'hF};
    endcase
  endfunction

  logic [3:0]  r_an, r_an_prev;
  logic [6:0]  r_seg, r_seg_prev;
  logic [7:0]  r_settle;
  logic        r_dwell_done;
  logic [3:0]  r_mask;
  logic [15:0] r_sh_val;
  logic [3:0]  r_sh_valid, r_sh_blank;
  logic [15:0] r_digits;
  logic [3:0]  r_digit_valid, r_blank;
  logic        r_frame_valid;
  logic [7:0]  r_frame_count;
  logic [23:0] r_tmo;
  logic        r_stale;

  logic        w_sel, w_change, w_dwell_eff, w_capture, w_commit;
  logic [1:0]  w_idx;
  logic [7:0]  w_settle_nxt;
  logic [3:0]  w_mask_nxt;
  logic [5:0]  w_dec;
  logic [15:0] w_sh_val_nxt;
  logic [3:0]  w_sh_valid_nxt, w_sh_blank_nxt;
  logic [23:0] w_tmo_nxt;

  always_comb begin
    w_sel = 1'b1;
    w_idx = 2'd0;
    case (r_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_sel = 1'b0;
    endcase
  end

  assign w_change = (r_an != r_an_prev) || (r_seg != r_seg_prev);

  // counter saturates at SETTLE-1; dwell-done keeps a long dwell to one capture
  always_comb begin
    w_settle_nxt = 8'd0;
    if (w_sel && !w_change)
      w_settle_nxt = (r_settle < SETTLE_M1) ? r_settle + 8'd1 : r_settle;
  end

  assign w_dwell_eff = w_sel && !w_change && r_dwell_done;
  assign w_capture   = w_sel && (w_settle_nxt == SETTLE_M1) && !w_dwell_eff;
  assign w_mask_nxt  = r_mask | (w_capture ? (4'b0001 << w_idx) : 4'b0000);
  assign w_commit    = w_capture && (w_mask_nxt == 4'b1111);
  assign w_dec       = decode_glyph(r_seg);

  always_comb begin
    w_sh_val_nxt   = r_sh_val;
    w_sh_valid_nxt = r_sh_valid;
    w_sh_blank_nxt = r_sh_blank;
    for (int i = 0; i < 4; i++) begin
      if (w_capture && (w_idx == 2'(i))) begin
        w_sh_val_nxt[4*i +: 4] = w_dec[3:0];
        w_sh_valid_nxt[i]      = w_dec[5];
        w_sh_blank_nxt[i]      = w_dec[4];
      end
    end
  end

  always_comb begin
    w_tmo_nxt = r_tmo;
    if (w_commit)
      w_tmo_nxt = 24'd0;
    else if (r_tmo != TMO_MAX)
      w_tmo_nxt = r_tmo + 24'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an          <= 4'd0;
      r_an_prev     <= 4'd0;
      r_seg         <= 7'd0;
      r_seg_prev    <= 7'd0;
      r_settle      <= 8'd0;
      r_dwell_done  <= 1'b0;
      r_mask        <= 4'd0;
      r_sh_val      <= 16'd0;
      r_sh_valid    <= 4'd0;
      r_sh_blank    <= 4'd0;
      r_digits      <= 16'd0;
      r_digit_valid <= 4'd0;
      r_blank       <= 4'd0;
      r_frame_valid <= 1'b0;
      r_frame_count <= 8'd0;
      r_tmo         <= 24'd0;
      r_stale       <= 1'b1;
    end else begin
      r_an          <= an;
      r_seg         <= seg;
      r_an_prev     <= r_an;
      r_seg_prev    <= r_seg;
      r_settle      <= w_settle_nxt;
      r_dwell_done  <= w_dwell_eff || w_capture;
      r_mask        <= w_commit ? 4'd0 : w_mask_nxt;
      r_sh_val      <= w_sh_val_nxt;
      r_sh_valid    <= w_sh_valid_nxt;
      r_sh_blank    <= w_sh_blank_nxt;
      r_frame_valid <= w_commit;
      r_tmo         <= w_tmo_nxt;
      r_stale       <= w_commit ? 1'b0 : (r_stale || (w_tmo_nxt == TMO_MAX));
      if (w_commit) begin
        r_digits      <= w_sh_val_nxt;
        r_digit_valid <= w_sh_valid_nxt;
        r_blank       <= w_sh_blank_nxt;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_digit_valid;
  assign blank       = r_blank;
  assign frame_valid = r_frame_valid;
  assign frame_count = r_frame_count;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - randomized scoreboard bench for seg_scan_decoder
// with a dwell-level reference model.
module tb_seg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_valid, blank;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        stale;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg),
    .digits(digits), .digit_valid(digit_valid), .blank(blank),
    .frame_valid(frame_valid), .frame_count(frame_count), .stale(stale)
  );

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] an_tab [7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1100, 4'b0000};

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  b;
    logic [7:0]  c;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] m_val [4];
  logic [3:0] m_ok, m_bl, m_mask;
  logic [7:0] m_count;
  logic [3:0] last_a = 4'hF;
  logic [6:0] last_s = 7'h7F;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_val[k] = 4'd0;
    m_ok = 4'd0; m_bl = 4'd0; m_mask = 4'd0; m_count = 8'd0;
  endtask

  // one dwell: hold an/seg for len cycles; model captures if held at least SETTLE cycles
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    int idx;
    logic [3:0] v;
    logic hit;
    frame_t f;
    idx = -1;
    case (a)
      4'b1110: idx = 0;
      4'b1101: idx = 1;
      4'b1011: idx = 2;
      4'b0111: idx = 3;
      default: idx = -1;
    endcase
    if (idx >= 0 && len >= SETTLE) begin
      hit = 1'b0;
      v = 4'hF;
      for (int k = 0; k < 16; k++)
        if (glyph[k] == s) begin hit = 1'b1; v = 4'(k); end
      m_bl[idx] = (s == 7'h7F);
      if (m_bl[idx]) v = 4'h0;
      m_val[idx] = v;
      m_ok[idx] = hit;
      m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin
        m_count = m_count + 8'd1;
        f.d = {m_val[3], m_val[2], m_val[1], m_val[0]};
        f.v = m_ok;
        f.b = m_bl;
        f.c = m_count;
        exp_q.push_back(f);
        m_mask = 4'd0;
      end
    end
    an = a;
    seg = s;
    last_a = a;
    last_s = s;
    repeat (len) @(negedge clk);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input int len);
    dwell(4'b1110, s0, len);
    dwell(4'b1101, s1, len);
    dwell(4'b1011, s2, len);
    dwell(4'b0111, s3, len);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    an = 4'hF;
    seg = 7'h7F;
    last_a = 4'hF;
    last_s = 7'h7F;
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_digit_valid", 32'(digit_valid), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);
    check("rst_stale", 32'(stale), 32'h1);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    frame_t e;
    forever begin
      @(negedge clk);
      if (!reset && frame_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got frame_count %0h expected no frame", frame_count);
        end else begin
          e = exp_q.pop_front();
          check("frame_digits", 32'(digits), 32'(e.d));
          check("frame_digit_valid", 32'(digit_valid), 32'(e.v));
          check("frame_blank", 32'(blank), 32'(e.b));
          check("frame_count", 32'(frame_count), 32'(e.c));
          check("frame_stale", 32'(stale), 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [3:0] a;
    logic [6:0] s;
    int r;
    model_reset();
    do_reset();

    repeat (3) scan4(glyph[5], glyph[0], glyph[3], glyph[9], 16);

    for (int p = 0; p < 100; p++) begin
      scan4(glyph[5], glyph[0], glyph[3], glyph[9], SETTLE - 1);
      if (p == 33) check("stale_early", 32'(stale), 32'h0);
    end
    check("stale_late", 32'(stale), 32'h1);

    scan4(glyph[1], glyph[2], glyph[3], 7'h7F, 8);
    scan4(glyph[4], glyph[6], 7'b1010101, glyph[8], 8);

    dwell(4'b1110, glyph[10], 8);
    dwell(4'b1101, glyph[11], 8);
    dwell(4'b1100, glyph[7], 50);
    dwell(4'b1111, glyph[7], 50);
    dwell(4'b1011, glyph[12], 8);
    dwell(4'b0111, glyph[13], 8);

    scan4(glyph[1], glyph[2], glyph[3], glyph[4], SETTLE);
    dwell(4'b1110, glyph[6], 8);
    dwell(4'b1101, glyph[7], SETTLE - 1);
    dwell(4'b1011, glyph[8], 8);
    dwell(4'b0111, glyph[9], 8);
    dwell(4'b1101, glyph[14], 8);
    dwell(4'b1110, glyph[15], 8);
    dwell(4'b1111, 7'h7F, 10);

    for (int n = 0; n < 300; n++) begin
      do begin
        a = an_tab[$urandom_range(0, 6)];
        r = int'($urandom_range(0, 9));
        if (r < 7) s = glyph[$urandom_range(0, 15)];
        else if (r == 7) s = 7'h7F;
        else s = 7'($urandom);
      end while (a == last_a && s == last_s);
      dwell(a, s, int'($urandom_range(1, SETTLE + 4)));
    end
    dwell(4'b1111, 7'h7F, 20);

    dwell(4'b1110, glyph[2], 8);
    dwell(4'b1101, glyph[3], 8);
    do_reset();
    scan4(glyph[7], glyph[8], glyph[9], glyph[10], 8);
    dwell(4'b1111, 7'h7F, 4);
    check("count_after_reset", 32'(frame_count), 32'h1);

    for (int f = 0; f < 256; f++)
      for (int d = 0; d < 4; d++)
        dwell(an_tab[d], glyph[$urandom_range(0, 15)], int'($urandom_range(SETTLE, SETTLE + 3)));
    dwell(4'b1111, 7'h7F, 20);
    check("count_wrap", 32'(frame_count), 32'h1);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
